fsk_decision_ctrl: RTL

Sequencer for the FSK bit-decision datapath. It takes single-precision low-pass filter samples and issues each one, with a programmable threshold, to the external floating-point subtract core over AXI-stream. It collects the sign of each result and majority-votes SAMPLES_PER_SYM decisions into one demodulated bit. It sits between the low-pass filter output and the bit sink, and replaces the free-running always-valid subtractor hookup.

---
 rtl/fsk_dec_pkg.sv | 13 +
 rtl/fsk_vote_accum.sv | 50 +++++
 rtl/fsk_decision_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fsk_dec_pkg.sv
// Shared types and constants for the FSK bit-decision sequencer.
package fsk_dec_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StEmit} state_e;

    localparam int unsigned FP_SIGN_BIT = 31;
    localparam logic [31:0] THRESH_DEFAULT_C = 32'h4FA8FABA;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fsk_vote_accum.sv
// Per-symbol vote accumulator: sample count, count of 'one' decisions, majority/tie flags.
module fsk_vote_accum
    import fsk_dec_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_SYM = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic last_o,
    output logic maj_o,
    output logic tie_o
);

    localparam int unsigned CW = cnt_width(SAMPLES_PER_SYM);

    logic [CW-1:0] cnt_q, cnt_d, ones_q, ones_d;
    logic [CW:0]   ones_x2;

    always_comb begin
        cnt_d  = cnt_q;
        ones_d = ones_q;
        if (clr_i) begin
            cnt_d  = '0;
            ones_d = '0;
        end else if (inc_i) begin
            cnt_d  = cnt_q + CW'(1);
            ones_d = ones_q + CW'(dec_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

    // Compare 2*ones against the sample count so odd symbol lengths never tie.
    assign ones_x2 = {ones_q, 1'b0};
    assign last_o  = (cnt_q == CW'(SAMPLES_PER_SYM - 1));
    assign maj_o   = (ones_x2 > (CW + 1)'(SAMPLES_PER_SYM));
    assign tie_o   = (ones_x2 == (CW + 1)'(SAMPLES_PER_SYM));

endmodule

// File: rtl/fsk_decision_ctrl.sv
// FSK decision sequencer: feeds samples and threshold to an external FP subtract core and
// majority-votes result signs per symbol. DECISION_AMBIG_CNT_EN adds ambig_count.
module fsk_decision_ctrl
    import fsk_dec_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_SYM = 8,
    parameter int unsigned TIMEOUT_CYC     = 64,
    parameter logic [31:0] THRESH_DEFAULT  = THRESH_DEFAULT_C
) (
    input  logic        in_clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [31:0] thr_in,
    input  logic        thr_load,
    input  logic        sym_restart,
    output logic [31:0] sub_a_tdata,
    output logic        sub_a_tvalid,
    input  logic        sub_a_tready,
    output logic [31:0] sub_b_tdata,
    output logic        sub_b_tvalid,
    input  logic        sub_b_tready,
    input  logic [31:0] sub_res_tdata,
    input  logic        sub_res_tvalid,
    output logic        sub_res_tready,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        sym_ambig,
    output logic        timeout_err,
`ifdef DECISION_AMBIG_CNT_EN
    output logic [15:0] ambig_count,
`endif
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    state_e        state_q, state_d;
    logic [31:0]   a_q, b_q, thr_q;
    logic          a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          discard_q, discard_d;
    logic          bit_q, err_q;
    logic          sample_hs, hs_a, hs_b, res_hs, abort, emit, bit_new;
    logic          vote_inc, vote_clr, vote_last, vote_maj, vote_tie;
    logic          res_unused;

    assign sample_ready   = en && (state_q == StIdle);
    assign sample_hs      = sample_ready && sample_valid;
    assign sub_a_tvalid   = (state_q == StIssue) && a_pend_q;
    assign sub_b_tvalid   = (state_q == StIssue) && b_pend_q;
    assign hs_a           = sub_a_tvalid && sub_a_tready;
    assign hs_b           = sub_b_tvalid && sub_b_tready;
    assign sub_res_tready = (state_q == StWait);
    assign res_hs         = sub_res_tready && sub_res_tvalid;
    assign emit           = (state_q == StEmit);
    assign res_unused     = ^sub_res_tdata[FP_SIGN_BIT-1:0];

    // A restart seen while this sample was in flight voids its decision.
    assign vote_inc = res_hs && !discard_q && !sym_restart;
    assign vote_clr = sym_restart || emit || abort;

    always_comb begin
        state_d   = state_q;
        a_pend_d  = a_pend_q;
        b_pend_d  = b_pend_q;
        tmo_d     = tmo_q;
        abort     = 1'b0;
        discard_d = discard_q ||
                    (sym_restart && (state_q == StIssue || state_q == StWait));
        unique case (state_q)
            StIdle: begin
                if (sample_hs) begin
                    state_d   = StIssue;
                    a_pend_d  = 1'b1;
                    b_pend_d  = 1'b1;
                    tmo_d     = '0;
                    discard_d = 1'b0;
                end
            end
            StIssue: begin
                if (hs_a) a_pend_d = 1'b0;
                if (hs_b) b_pend_d = 1'b0;
                if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (!a_pend_d && !b_pend_d) state_d = StWait;
                end
            end
            StWait: begin
                if (res_hs) begin
                    state_d = (vote_inc && vote_last) ? StEmit : StIdle;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StEmit:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d  = StIdle;
            a_pend_d = 1'b0;
            b_pend_d = 1'b0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_pend_q  <= 1'b0;
            b_pend_q  <= 1'b0;
            tmo_q     <= '0;
            discard_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            thr_q     <= THRESH_DEFAULT;
            bit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_pend_q  <= a_pend_d;
            b_pend_q  <= b_pend_d;
            tmo_q     <= tmo_d;
            discard_q <= discard_d;
            if (thr_load) thr_q <= thr_in;
            if (sample_hs) begin
                a_q <= sample_in;
                b_q <= thr_q;
            end
            if (emit)  bit_q <= bit_new;
            if (abort) err_q <= 1'b1;
        end
    end

    fsk_vote_accum #(
        .SAMPLES_PER_SYM(SAMPLES_PER_SYM)
    ) u_vote (
        .clk_i (in_clk),
        .rst_i (reset),
        .clr_i (vote_clr),
        .inc_i (vote_inc),
        .dec_i (~sub_res_tdata[FP_SIGN_BIT]),
        .last_o(vote_last),
        .maj_o (vote_maj),
        .tie_o (vote_tie)
    );

    // On a tie the previous bit is held.
    assign bit_new     = vote_maj ? 1'b1 : (vote_tie ? bit_q : 1'b0);
    assign bit_out     = emit ? bit_new : bit_q;
    assign bit_valid   = emit;
    assign sym_ambig   = emit && vote_tie;
    assign timeout_err = err_q;
    assign busy        = (state_q != StIdle);
    assign sub_a_tdata = a_q;
    assign sub_b_tdata = b_q;

`ifdef DECISION_AMBIG_CNT_EN
    logic [15:0] amb_cnt_q;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            amb_cnt_q <= '0;
        end else if ((sym_ambig || abort) && amb_cnt_q != 16'hFFFF) begin
            amb_cnt_q <= amb_cnt_q + 16'd1;
        end
    end

    assign ambig_count = amb_cnt_q;
`endif

endmodule
